// File: rtl/bram_stream_reader.sv
// Burst reader: streams cmdLength words from block RAM starting at cmdAddress, one word per cycle.
// First word valid two cycles after command accept; backpressure gates the RAM enable so the RAM output register holds the word.
module bram_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic [ADDR_WIDTH-1:0] cmdAddress,
  input  logic [LEN_WIDTH-1:0]  cmdLength,
  output logic                  ramEnable,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  input  logic [DATA_WIDTH-1:0] ramDataOut,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outLast,
  output logic                  busy,
  output logic                  donePulse
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [LEN_WIDTH-1:0]   remaining;
  logic                   issue;
  logic                   accept;
  logic                   accept_empty;
  logic                   last_taken;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    cmdReady     = 1'b0;
    busy         = 1'b0;
    issue        = 1'b0;
    accept       = 1'b0;
    accept_empty = 1'b0;
    last_taken   = 1'b0;
    case (state)
      IDLE: begin
        cmdReady = 1'b1;
        if (cmdValid) begin
          if (cmdLength == '0) begin
            accept_empty = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = READ;
          end
        end
      end
      READ: begin
        busy = 1'b1;
        // Next read only when the output stage is empty or being drained this cycle.
        issue      = (remaining != '0) && (!outValid || outReady);
        last_taken = outValid && outReady && outLast;
        if (last_taken) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The RAM output register is the only data stage, so the stream word is the RAM output.
  assign ramEnable = issue;
  assign outData   = ramDataOut;

  always_ff @(posedge clock) begin
    if (reset) begin
      ramAddress <= '0;
      remaining  <= '0;
      outValid   <= 1'b0;
      outLast    <= 1'b0;
      donePulse  <= 1'b0;
    end else begin
      donePulse <= accept_empty || last_taken;
      if (accept) begin
        ramAddress <= cmdAddress;
        remaining  <= cmdLength;
      end
      if (issue) begin
        ramAddress <= ramAddress + ADDR_WIDTH'(1);
        remaining  <= remaining - LEN_WIDTH'(1);
        outValid   <= 1'b1;
        outLast    <= (remaining == LEN_WIDTH'(1));
      end else if (outValid && outReady) begin
        outValid <= 1'b0;
        outLast  <= 1'b0;
      end
    end
  end

endmodule
